// File: rtl/dmem_io_ctrl.sv
// Memory-mapped board I/O on the data-memory bus: debounced switches, event latches, 7-seg display.
// Optional free-running TIMER register built only when DMEM_IO_TIMER_EN is defined.
module dmem_io_ctrl #(
  parameter logic [15:0] IO_BASE         = 16'hFFF0,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMER_DIV       = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        write,
  input  logic        read,
  input  logic        sw0,
  input  logic        sw1,
  output logic [15:0] rdata,
  output logic        hit,
  output logic [6:0]  display
);

  localparam logic [15:0] DEB_LIM = 16'(DEBOUNCE_CYCLES);

  logic [1:0]  w_off;
  logic        w_wr_disp;
  logic        w_rd_ev;
  logic [1:0]  w_flip;
  logic [1:0]  w_rise;
  logic [15:0] w_cnt_inc [2];
  logic [15:0] w_timer;
  logic        w_unused_bits;

  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_stable;
  logic [15:0] r_cnt [2];
  logic [1:0]  r_ev;
  logic [3:0]  r_disp;

  assign hit       = (addr[15:3] == IO_BASE[15:3]);
  assign w_off     = addr[2:1];
  assign w_wr_disp = hit & write & (w_off == 2'd1);
  assign w_rd_ev   = hit & read & (w_off == 2'd2);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_cnt_inc[i] = r_cnt[i] + 16'd1;
      w_flip[i]    = (r_sync2[i] != r_stable[i]) && (w_cnt_inc[i] == DEB_LIM);
      w_rise[i]    = w_flip[i] & r_sync2[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_ev     <= '0;
      r_disp   <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {sw1, sw0};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= w_cnt_inc[i];
        end
      end
      // A new rising edge outranks a read-clear landing on the same clock.
      r_ev <= w_rise | (r_ev & {2{~w_rd_ev}});
      if (w_wr_disp) r_disp <= wdata[3:0];
    end
  end

`ifdef DMEM_IO_TIMER_EN
  logic        w_wr_tmr;
  logic [31:0] r_presc;
  logic [15:0] r_timer;

  assign w_wr_tmr = hit & write & (w_off == 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (w_wr_tmr) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (r_presc == 32'(TIMER_DIV - 1)) begin
      r_presc <= '0;
      r_timer <= r_timer + 16'd1;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  assign w_timer       = r_timer;
  assign w_unused_bits = ^{wdata[15:4], addr[0]};
`else
  assign w_timer       = 16'h0000;
  assign w_unused_bits = ^{wdata[15:4], addr[0], TIMER_DIV[0]};
`endif

  always_comb begin
    rdata = 16'h0000;
    if (hit && read) begin
      case (w_off)
        2'd0:    rdata = {14'b0, r_stable};
        2'd1:    rdata = {12'b0, r_disp};
        2'd2:    rdata = {14'b0, r_ev};
        default: rdata = w_timer;
      endcase
    end
  end

  // Segments {g,f,e,d,c,b,a}, driven low to light.
  always_comb begin
    case (r_disp)
      4'h0:    display = 7'b1000000;
      4'h1:    display = 7'b1111001;
      4'h2:    display = 7'b0100100;
      4'h3:    display = 7'b0110000;
      4'h4:    display = 7'b0011001;
      4'h5:    display = 7'b0010010;
      4'h6:    display = 7'b0000010;
      4'h7:    display = 7'b1111000;
      4'h8:    display = 7'b0000000;
      4'h9:    display = 7'b0010000;
      4'hA:    display = 7'b0001000;
      4'hB:    display = 7'b0000011;
      4'hC:    display = 7'b1000110;
      4'hD:    display = 7'b0100001;
      4'hE:    display = 7'b0000110;
      default: display = 7'b0001110;
    endcase
  end

endmodule

// File: doc/dmem_io_ctrl.md
Name: dmem_io_ctrl

Overview:
- Memory-mapped I/O controller on the processor data-memory bus, beside the data RAM; decodes the top I/O page and serves board I/O.
- Inputs: two sliding switches, synchronised and debounced, with rising-edge event latches.
- Output: a hex value driven to the 7-segment display.
- The data-memory wrapper muxes this block's read data in whenever `hit`=1.

Parameters:
- IO_BASE, 16'hFFF0, base of the 8-byte I/O page; decode is addr[15:3] == IO_BASE[15:3].
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised switch level must differ from the stable level before the stable level flips (legal range 2..65535).
- TIMER_DIV, 1000, clock cycles per timer tick (TIMER_EN only).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- addr, input, 16, data-memory byte address.
- wdata, input, 16, data-memory write data.
- write, input, 1, data-memory write enable.
- read, input, 1, data-memory read enable.
- sw0, input, 1, raw sliding switch 0 (asynchronous).
- sw1, input, 1, raw sliding switch 1 (asynchronous).
- rdata, output, 16, read data; valid when hit=1.
- hit, output, 1, addr is inside the I/O page.
- display, output, 7, segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Register map (addr[2:1]; addr[0] ignored):
  - 0 = SW_STATUS (RO): {14'b0, stable1, stable0}.
  - 1 = DISPLAY (RW): {12'b0, disp_val[3:0]}.
  - 2 = SW_EVENT (RO, read-clear): {14'b0, ev1, ev0}.
  - 3 = TIMER (RO).
- Bus decode:
  - hit is combinational from addr only.
  - rdata is combinational: register contents when hit & read, else 16'h0000.
  - Writes take effect on the clock edge when hit & write & (addr[2:1]==1); disp_val <= wdata[3:0].
  - Writes to offsets 0, 2, 3 are ignored.
- Synchroniser: each switch passes through 2 flops (sync_n); raw-to-sync latency is 2 cycles.
- Debouncer, per switch: 16-bit counter.
  - While sync_n == stable_n, the counter clears to 0.
  - Otherwise it increments. When it would reach DEBOUNCE_CYCLES, stable_n <= sync_n and the counter clears on that same edge.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable_n.
  - Total latency from raw edge to stable change is 2 + DEBOUNCE_CYCLES cycles.
- Event latch: ev_n sets on the edge where stable_n goes 0->1.
  - A read of SW_EVENT (hit & read & addr[2:1]==2) clears both ev bits on that edge. The read returns the pre-clear value.
  - Simultaneous set and clear on one edge: the set wins, so the new event is not lost.
- Display: display = 7-segment encoding of disp_val (hex 0-F, active-low), e.g. 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
- Simultaneous read and write to DISPLAY in one cycle: rdata shows the old value; the new value is visible from the next cycle.
- Reset (async, reset=0):
  - sync, stable, counters, ev, disp_val and timer all go to 0, so display = 7'b1000000.
  - rdata and hit remain combinational.
  - Reset asserted mid-debounce abandons the count. After release, a switch held at 1 requires the full 2 + DEBOUNCE_CYCLES cycles and then sets ev.

Optional Feature:
- Macro: DMEM_IO_TIMER_EN.
- Defined:
  - A prescaler counts 0..TIMER_DIV-1. On wrap, the 16-bit TIMER register increments, wrapping FFFF->0000.
  - A write to offset 3 clears both TIMER and the prescaler on that edge; the write data is ignored.
- Undefined: no timer logic is built, and reads of offset 3 return 16'h0000.

Test Plan (DEBOUNCE_CYCLES=4, TIMER_DIV=3):
- Reset with reset=0, then release -> display=7'b1000000; read 16'hFFF0 returns 0; read 16'hFFF4 returns 0; hit=1 for 16'hFFF6, hit=0 for 16'hFFE0.
- Write 16'h000A to 16'hFFF2, then read 16'hFFF2 -> rdata=16'h000A; display=7'b0001000 ('A'). Write to 16'hFFF0 -> SW_STATUS unchanged.
- sw1 0->1 held -> SW_STATUS reads 16'h0002 exactly 6 cycles after the edge, not at 5. The first SW_EVENT read returns 16'h0002 and the second returns 16'h0000.
- sw0 pulsed high for 3 cycles -> SW_STATUS and SW_EVENT stay 0. Reset pulsed low during a 6-cycle sw0 assertion -> no event until the full 6 cycles after release.
- Stable0 rising on the same edge as an SW_EVENT read -> that read returns 0; the next read returns 16'h0001.
- DMEM_IO_TIMER_EN defined -> TIMER reads 3 after 9 cycles; write to 16'hFFF6 -> reads 0 the next cycle. Macro undefined -> TIMER always reads 0.
